// File: rtl/revo_lock_sequencer_pkg.sv
// Shared definitions for the revo lock sequencer: state encoding, default
// timeout constants and a saturating counter helper.
`timescale 1ns/1ps
package revo_lock_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_WAIT_PLL = 3'd1,
        ST_SEARCH   = 3'd2,
        ST_RUN      = 3'd3,
        ST_FAIL     = 3'd4
    } state_t;

    localparam int DEF_HOLD_CYCLES       = 1024;
    localparam int DEF_LOCK_TIMEOUT      = 1048576;
    localparam int DEF_PHASE_TIMEOUT     = 4194304;
    localparam int DEF_HEARTBEAT_TIMEOUT = 256;
    localparam int DEF_REVO_TIMEOUT      = 8388608;
    localparam int DEF_MAX_RETRIES       = 3;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/async_event_sync.sv
// Two-flop synchronizer with change detection; o_event pulses for one cycle
// on every toggle of the input, visible two cycles after the input moves.
`timescale 1ns/1ps
module async_event_sync (
    input  logic local_clock50,
    input  logic reset,
    input  logic i_async,
    output logic o_level,
    output logic o_event
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge local_clock50 or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_event = r_sync ^ r_prev;

endmodule

// File: rtl/revo_lock_sequencer.sv
// Clock bring-up sequencer: resets the PLL, waits for PLL and revo phase lock,
// falls back from the remote to the local 509 source and finally gives up.
`timescale 1ns/1ps
module revo_lock_sequencer
    import revo_lock_sequencer_pkg::*;
#(
    parameter int HOLD_CYCLES       = DEF_HOLD_CYCLES,
    parameter int LOCK_TIMEOUT      = DEF_LOCK_TIMEOUT,
    parameter int PHASE_TIMEOUT     = DEF_PHASE_TIMEOUT,
    parameter int HEARTBEAT_TIMEOUT = DEF_HEARTBEAT_TIMEOUT,
    parameter int REVO_TIMEOUT      = DEF_REVO_TIMEOUT,
    parameter int MAX_RETRIES       = DEF_MAX_RETRIES
) (
    input  logic       local_clock50,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       phase_locked,
    input  logic       heartbeat,
    input  logic       revo_toggle,
    output logic       pll_reset,
    output logic       phase_reset,
    output logic       clock_select,
    output logic       fake_revo_enable,
    output logic       ready,
    output logic       error,
    output logic [2:0] state,
    output logic [1:0] retry_count
);

    logic [3:0] w_async;
    logic [3:0] w_level;
    logic [3:0] w_event;
    logic       w_unused;

    assign w_async = {revo_toggle, heartbeat, phase_locked, pll_locked};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sync
            async_event_sync u_sync (
                .local_clock50 (local_clock50),
                .reset         (reset),
                .i_async       (w_async[gi]),
                .o_level       (w_level[gi]),
                .o_event       (w_event[gi])
            );
        end
    endgenerate

    logic w_pll_ok, w_phase_ok, w_hb_event, w_revo_event;
    assign w_pll_ok     = w_level[0];
    assign w_phase_ok   = w_level[1];
    assign w_hb_event   = w_event[2];
    assign w_revo_event = w_event[3];
    assign w_unused     = ^{w_level[3:2], w_event[1:0]};

    // Reset release is re-timed here; the FSM is pinned in HOLD until it clears.
    logic [1:0] r_rst_sync;
    always_ff @(posedge local_clock50 or posedge reset) begin
        if (reset) r_rst_sync <= 2'b11;
        else       r_rst_sync <= {r_rst_sync[0], 1'b0};
    end

    state_t      r_state, w_state_next;
    logic [31:0] r_timer, r_hb_timer, r_revo_timer;
    logic        r_clock_select, w_clock_select_next;
    logic [1:0]  r_retry_count, w_retry_next;
    logic        r_fake_revo, w_fake_revo_next;
    logic        r_pll_reset, r_phase_reset, r_ready, r_error;
    logic        w_hb_timeout, w_do_retry, w_do_fallback, w_entry;

    assign w_hb_timeout = !w_hb_event && (r_hb_timer >= 32'(HEARTBEAT_TIMEOUT - 1));

    always_comb begin
        w_state_next        = r_state;
        w_clock_select_next = r_clock_select;
        w_retry_next        = r_retry_count;
        w_fake_revo_next    = r_fake_revo;
        w_do_retry          = 1'b0;
        w_do_fallback       = 1'b0;

        // Branch order encodes the priority: heartbeat > lock loss > timeout > success.
        case (r_state)
            ST_HOLD: begin
                if (r_timer >= 32'(HOLD_CYCLES - 1)) w_state_next = ST_WAIT_PLL;
            end
            ST_WAIT_PLL: begin
                if (w_hb_timeout)                            w_do_fallback = 1'b1;
                else if (r_timer >= 32'(LOCK_TIMEOUT - 1))   w_do_retry    = 1'b1;
                else if (w_pll_ok)                           w_state_next  = ST_SEARCH;
            end
            ST_SEARCH: begin
                if (w_hb_timeout)                            w_do_fallback = 1'b1;
                else if (!w_pll_ok)                          w_state_next  = ST_HOLD;
                else if (r_timer >= 32'(PHASE_TIMEOUT - 1))  w_do_retry    = 1'b1;
                else if (w_phase_ok)                         w_state_next  = ST_RUN;
            end
            ST_RUN: begin
                if (w_hb_timeout)                            w_do_fallback = 1'b1;
                else if (!w_pll_ok)                          w_state_next  = ST_HOLD;
            end
            default: w_state_next = ST_FAIL;
        endcase

        if (w_do_retry) begin
            if (int'(r_retry_count) + 1 >= MAX_RETRIES) begin
                w_do_fallback = 1'b1;
            end else begin
                w_retry_next = r_retry_count + 2'd1;
                w_state_next = ST_HOLD;
            end
        end

        if (w_do_fallback) begin
            if (!r_clock_select) begin
                w_clock_select_next = 1'b1;
                w_retry_next        = 2'd0;
                w_state_next        = ST_HOLD;
            end else begin
                w_state_next = ST_FAIL;
            end
        end

        if (w_state_next == ST_RUN && r_state != ST_RUN) w_retry_next = 2'd0;

        if (w_state_next != ST_RUN || r_state != ST_RUN)     w_fake_revo_next = 1'b0;
        else if (w_revo_event)                               w_fake_revo_next = 1'b0;
        else if (r_revo_timer >= 32'(REVO_TIMEOUT - 1))      w_fake_revo_next = 1'b1;

        if (r_rst_sync[1]) begin
            w_state_next        = ST_HOLD;
            w_clock_select_next = 1'b0;
            w_retry_next        = 2'd0;
            w_fake_revo_next    = 1'b0;
        end
    end

    assign w_entry = (w_state_next != r_state) || r_rst_sync[1];

    always_ff @(posedge local_clock50 or posedge reset) begin
        if (reset) begin
            r_state        <= ST_HOLD;
            r_timer        <= '0;
            r_hb_timer     <= '0;
            r_revo_timer   <= '0;
            r_clock_select <= 1'b0;
            r_retry_count  <= 2'd0;
            r_fake_revo    <= 1'b0;
            r_pll_reset    <= 1'b1;
            r_phase_reset  <= 1'b1;
            r_ready        <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_timer        <= w_entry ? '0 : sat_inc(r_timer);
            r_hb_timer     <= (w_entry || w_hb_event) ? '0 : sat_inc(r_hb_timer);
            r_revo_timer   <= (w_entry || w_revo_event) ? '0 : sat_inc(r_revo_timer);
            r_clock_select <= w_clock_select_next;
            r_retry_count  <= w_retry_next;
            r_fake_revo    <= w_fake_revo_next;
            r_pll_reset    <= (w_state_next == ST_HOLD) || (w_state_next == ST_FAIL);
            r_phase_reset  <= (w_state_next == ST_HOLD) || (w_state_next == ST_WAIT_PLL) ||
                              (w_state_next == ST_FAIL);
            r_ready        <= (w_state_next == ST_RUN);
            r_error        <= (w_state_next == ST_FAIL);
        end
    end

    assign state            = r_state;
    assign pll_reset        = r_pll_reset;
    assign phase_reset      = r_phase_reset;
    assign clock_select     = r_clock_select;
    assign fake_revo_enable = r_fake_revo;
    assign ready            = r_ready;
    assign error            = r_error;
    assign retry_count      = r_retry_count;

endmodule

// File: tb/tb_revo_lock_sequencer.sv
// Directed bench for revo_lock_sequencer with small timeouts; cycle numbers
// below count rising edges after reset release.
`timescale 1ns/1ps
module tb_revo_lock_sequencer;
    import revo_lock_sequencer_pkg::*;

    logic       local_clock50 = 1'b0;
    logic       reset = 1'b1;
    logic       pll_locked = 1'b0;
    logic       phase_locked = 1'b0;
    logic       heartbeat = 1'b0;
    logic       revo_toggle = 1'b0;
    logic       pll_reset, phase_reset, clock_select, fake_revo_enable, ready, error;
    logic [2:0] state;
    logic [1:0] retry_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int hb_ph = 0;
    int last_hb = 0;
    bit hb_on = 1'b1;
    int t0;

    revo_lock_sequencer #(
        .HOLD_CYCLES(8), .LOCK_TIMEOUT(64), .PHASE_TIMEOUT(128),
        .HEARTBEAT_TIMEOUT(16), .REVO_TIMEOUT(32), .MAX_RETRIES(3)
    ) dut (
        .local_clock50(local_clock50), .reset(reset),
        .pll_locked(pll_locked), .phase_locked(phase_locked),
        .heartbeat(heartbeat), .revo_toggle(revo_toggle),
        .pll_reset(pll_reset), .phase_reset(phase_reset),
        .clock_select(clock_select), .fake_revo_enable(fake_revo_enable),
        .ready(ready), .error(error), .state(state), .retry_count(retry_count)
    );

    always #5 local_clock50 = ~local_clock50;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end else begin
            $display("ok   %s @cyc %0d: %0d", tag, cyc, got);
        end
    endtask

    // One clock, then drive/sample 1 ns after the edge; heartbeat toggles every 4 cycles.
    task automatic tick();
        @(posedge local_clock50);
        #1;
        cyc++;
        if (hb_on) begin
            hb_ph++;
            if (hb_ph == 4) begin
                hb_ph = 0;
                heartbeat = ~heartbeat;
                last_hb = cyc;
            end
        end
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int max_cyc);
        int n = 0;
        while (state !== s && n < max_cyc) begin
            tick();
            n++;
        end
        check_val(tag, {29'd0, state}, {29'd0, s});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        check_val("rst_state", {29'd0, state}, 32'd0);
        check_val("rst_pll_reset", {31'd0, pll_reset}, 32'd1);
        check_val("rst_phase_reset", {31'd0, phase_reset}, 32'd1);
        check_val("rst_clock_select", {31'd0, clock_select}, 32'd0);
        check_val("rst_ready_error", {30'd0, ready, error}, 32'd0);
        check_val("rst_retry", {30'd0, retry_count}, 32'd0);
        reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Normal bring-up on the remote source.
        pll_locked = 1'b0; phase_locked = 1'b0; hb_on = 1'b1;
        do_reset();
        run_to(9);  check_val("hold_pll_reset", {31'd0, pll_reset}, 32'd1);
        run_to(10); check_val("wait_pll_reset", {31'd0, pll_reset}, 32'd0);
                    check_val("wait_phase_reset", {31'd0, phase_reset}, 32'd1);
                    check_val("wait_state", {29'd0, state}, 32'd1);
        run_to(20); pll_locked = 1'b1;
        run_to(22); check_val("pre_search", {29'd0, state}, 32'd1);
        run_to(23); check_val("search", {29'd0, state}, 32'd2);
                    check_val("search_phase_reset", {31'd0, phase_reset}, 32'd0);
        run_to(40); phase_locked = 1'b1;
        run_to(42); check_val("pre_run", {29'd0, state}, 32'd2);
        run_to(43); check_val("run", {29'd0, state}, 32'd3);
                    check_val("run_ready", {31'd0, ready}, 32'd1);
                    check_val("run_retry", {30'd0, retry_count}, 32'd0);

        // Fake revo after 32 silent cycles in RUN, cleared by one toggle.
        run_to(74); check_val("fake_off", {31'd0, fake_revo_enable}, 32'd0);
        run_to(75); check_val("fake_on", {31'd0, fake_revo_enable}, 32'd1);
        run_to(80); revo_toggle = 1'b1;
        run_to(82); check_val("fake_still_on", {31'd0, fake_revo_enable}, 32'd1);
        run_to(83); check_val("fake_cleared", {31'd0, fake_revo_enable}, 32'd0);

        // Lock loss alone: back to HOLD, nothing else changes.
        run_to(90); pll_locked = 1'b0;
        run_to(92); check_val("loss_pre", {29'd0, state}, 32'd3);
        run_to(93); check_val("loss_hold", {29'd0, state}, 32'd0);
                    check_val("loss_clock_select", {31'd0, clock_select}, 32'd0);
                    check_val("loss_retry", {30'd0, retry_count}, 32'd0);
        pll_locked = 1'b1;
        wait_state("relock_run", 3'd3, 40);

        // Heartbeat timeout and lock loss decided on the same cycle: heartbeat wins.
        hb_on = 1'b0;
        t0 = last_hb;
        run_to(t0 + 16); pll_locked = 1'b0;
        run_to(t0 + 18); check_val("hb_pre", {29'd0, state}, 32'd3);
        run_to(t0 + 19); check_val("hb_hold", {29'd0, state}, 32'd0);
                         check_val("hb_clock_select", {31'd0, clock_select}, 32'd1);
                         check_val("hb_ready", {31'd0, ready}, 32'd0);
                         check_val("hb_pll_reset", {31'd0, pll_reset}, 32'd1);
        hb_on = 1'b1; pll_locked = 1'b1;
        wait_state("local_run", 3'd3, 40);
        check_val("local_clock_select", {31'd0, clock_select}, 32'd1);

        // Heartbeat lost again on the local source: terminal FAIL.
        hb_on = 1'b0;
        t0 = last_hb;
        run_to(t0 + 18); check_val("hb2_pre", {31'd0, ready}, 32'd1);
        run_to(t0 + 19); check_val("hb2_fail", {29'd0, state}, 32'd4);
                         check_val("hb2_error", {31'd0, error}, 32'd1);
                         check_val("hb2_resets", {30'd0, pll_reset, phase_reset}, 32'd3);
        hb_on = 1'b1;
        run_to(t0 + 40); check_val("fail_sticky", {29'd0, state}, 32'd4);

        // PLL never locks: three retries per source.
        pll_locked = 1'b0; phase_locked = 1'b0; hb_on = 1'b1;
        do_reset();
        run_to(73);  check_val("r1_pre", {29'd0, state}, 32'd1);
        run_to(74);  check_val("r1_state", {29'd0, state}, 32'd0);
                     check_val("r1_count", {30'd0, retry_count}, 32'd1);
        run_to(146); check_val("r2_count", {30'd0, retry_count}, 32'd2);
        run_to(217); check_val("r3_pre", {31'd0, clock_select}, 32'd0);
        run_to(218); check_val("r3_clock_select", {31'd0, clock_select}, 32'd1);
                     check_val("r3_count", {30'd0, retry_count}, 32'd0);
                     check_val("r3_state", {29'd0, state}, 32'd0);
        run_to(290); check_val("l1_count", {30'd0, retry_count}, 32'd1);
        run_to(433); check_val("l3_pre", {29'd0, state}, 32'd1);
        run_to(434); check_val("l3_fail", {29'd0, state}, 32'd4);
                     check_val("l3_error", {31'd0, error}, 32'd1);

        // Reset pulse during SEARCH.
        pll_locked = 1'b0; phase_locked = 1'b0; hb_on = 1'b1;
        do_reset();
        run_to(20); pll_locked = 1'b1;
        run_to(30); check_val("s_search", {29'd0, state}, 32'd2);
        reset = 1'b1;
        #1;
        check_val("s_rst_state", {29'd0, state}, 32'd0);
        check_val("s_rst_resets", {30'd0, pll_reset, phase_reset}, 32'd3);
        check_val("s_rst_flags", {28'd0, clock_select, fake_revo_enable, ready, error}, 32'd0);
        tick();
        reset = 1'b0;
        cyc = 0;
        run_to(9);  check_val("s_hold", {29'd0, state}, 32'd0);
        run_to(10); check_val("s_wait", {29'd0, state}, 32'd1);
        run_to(11); check_val("s_search2", {29'd0, state}, 32'd2);
        phase_locked = 1'b1;
        run_to(14); check_val("s_run", {29'd0, state}, 32'd3);
                    check_val("s_ready", {31'd0, ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
